mole_scheduler: RTL and testbench

- Downstream consumer of the 3-bit LFSR (lfsr_3bit) in the whack-a-mole game.
- Requests a new LFSR value, maps it non-uniformly to a box 1-4, and shows the mole for a bounded window.
- Scores hits and misses, and ends the round after a fixed number of moles.
- Outputs drive the box LEDs/VGA and the score HEX decoders.

---
 rtl/mole_scheduler_if.sv | 28 ++
 rtl/mole_scheduler.sv | 156 +++++++++++++++
 tb/tb_mole_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mole_scheduler_if.sv
// Whack-a-mole scheduler bus: start/LFSR/hit inputs, mole/score outputs.
// master = game top/bench, slave = mole_scheduler.
interface mole_scheduler_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [2:0]         lfsr_state;
  logic [3:0]         hit;
  logic               lfsr_enable;
  logic [3:0]         mole;
  logic [2:0]         box_id;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic [7:0]         moles_left;
  logic               game_over;

  modport master (
    output start, lfsr_state, hit,
    input  lfsr_enable, mole, box_id,
    input  score, misses, moles_left, game_over
  );

  modport slave (
    input  start, lfsr_state, hit,
    output lfsr_enable, mole, box_id,
    output score, misses, moles_left, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// Mole scheduler: picks a box from lfsr_3bit, shows it, scores hits/misses.
// Ports: clk, reset (async, active-high), bus (mole_scheduler_if.slave).
module mole_scheduler #(
  parameter int UP_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int ROUND_LEN  = 20,
  parameter int SCORE_W    = 8
) (
  input  logic clk,
  input  logic reset,
  mole_scheduler_if.slave bus
);

  localparam int MAXC =
    (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] UP_LD  = TW'(UP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
  localparam logic [7:0]    RLEN   = 8'(ROUND_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_PICK   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_UP     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         box_q, box_d;
  logic [2:0]         prev_q, prev_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_q, miss_d;
  logic [7:0]         left_q, left_d;

  logic [2:0] pick_box;
  logic [3:0] mole_vec;
  logic       hit_ok;
  logic       end_mole;

  // Non-uniform map: box 1 gets three codes, box 2 two.
  always_comb begin
    pick_box = 3'd0;
    case (bus.lfsr_state)
      3'b001, 3'b010, 3'b100: pick_box = 3'd1;
      3'b011, 3'b101:         pick_box = 3'd2;
      3'b110:                 pick_box = 3'd3;
      3'b111:                 pick_box = 3'd4;
      default:                pick_box = 3'd0;
    endcase
  end

  always_comb begin
    mole_vec = 4'b0000;
    unique case (1'b1)
      (box_q == 3'd1): mole_vec = 4'b0001;
      (box_q == 3'd2): mole_vec = 4'b0010;
      (box_q == 3'd3): mole_vec = 4'b0100;
      (box_q == 3'd4): mole_vec = 4'b1000;
      default:         mole_vec = 4'b0000;
    endcase
  end

  assign hit_ok = |(bus.hit & mole_vec);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    box_d    = box_q;
    prev_d   = prev_q;
    score_d  = score_q;
    miss_d   = miss_q;
    left_d   = left_q;
    end_mole = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          score_d = '0;
          miss_d  = '0;
          left_d  = RLEN;
          timer_d = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == '0) state_d = S_PICK;
        else               timer_d = timer_q - 1'b1;
      end
      S_PICK: state_d = S_SAMPLE;
      S_SAMPLE: begin
        // Re-pick on invalid code or a repeat of the last box.
        if (pick_box == 3'd0 || pick_box == prev_q) begin
          state_d = S_PICK;
        end else begin
          box_d   = pick_box;
          prev_d  = pick_box;
          timer_d = UP_LD;
          state_d = S_UP;
        end
      end
      S_UP: begin
        // A hit wins over a timeout in the same cycle.
        if (hit_ok) begin
          if (score_q != '1) score_d = score_q + 1'b1;
          end_mole = 1'b1;
        end else if (timer_q == '0) begin
          if (miss_q != '1) miss_d = miss_q + 1'b1;
          end_mole = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
        if (end_mole) begin
          box_d  = 3'd0;
          left_d = left_q - 1'b1;
          if (left_q == 8'd1) begin
            state_d = S_DONE;
          end else begin
            timer_d = GAP_LD;
            state_d = S_GAP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      box_q   <= 3'd0;
      prev_q  <= 3'd0;
      score_q <= '0;
      miss_q  <= '0;
      left_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      box_q   <= box_d;
      prev_q  <= prev_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      left_q  <= left_d;
    end
  end

  assign bus.lfsr_enable = (state_q == S_PICK);
  assign bus.mole        = mole_vec;
  assign bus.box_id      = box_q;
  assign bus.score       = score_q;
  assign bus.misses      = miss_q;
  assign bus.moles_left  = left_q;
  assign bus.game_over   = (state_q == S_DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: random rounds vs. a game-level model.
// Drives/samples on negedge; small timing params for fast runs.
module tb_mole_scheduler;

  localparam int UPC  = 4;
  localparam int GAPC = 2;
  localparam int RLEN = 5;
  localparam int SW   = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mole_scheduler_if #(.SCORE_W(SW)) bus ();

  mole_scheduler #(
    .UP_CYCLES (UPC),
    .GAP_CYCLES(GAPC),
    .ROUND_LEN (RLEN),
    .SCORE_W   (SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_score, m_miss, m_left, m_prev;
  int force_q[$];
  int box_map[8] = '{0, 1, 1, 2, 1, 2, 3, 4};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_pick(output int cnt);
    cnt = 0;
    while (bus.lfsr_enable !== 1'b1 && cnt < 20) begin
      tick;
      cnt++;
    end
  endtask

  task automatic do_pick(output int box, output int pulses);
    int v, tries;
    box = 0; pulses = 0; tries = 0;
    while (box == 0) begin
      check("pick_en", bus.lfsr_enable, 1);
      pulses++;
      if (force_q.size() != 0) v = force_q.pop_front();
      else if (tries >= 6) v = (m_prev == 1) ? 6 : 1;
      else v = $urandom_range(0, 7);
      bus.lfsr_state = 3'(v);
      tick;
      check("sample_en", bus.lfsr_enable, 0);
      check("sample_mole", bus.mole, 0);
      tries++;
      if (box_map[v] != 0 && box_map[v] != m_prev) box = box_map[v];
      tick;
    end
    m_prev = box;
    bus.lfsr_state = 3'($urandom_range(0, 7));
  endtask

  // mode 0: no hit, 1: correct hit on UP cycle k, 2: wrong-box hits
  task automatic run_mole(input int mode, input int k,
                          output int box, output int pulses);
    int cnt, up_n;
    bit hitd;
    box = 0; pulses = 0;
    wait_pick(cnt);
    check("gap_len", cnt, GAPC);
    if (cnt >= 20) return;
    do_pick(box, pulses);
    hitd = 0; up_n = 0;
    for (int j = 0; j < UPC && !hitd; j++) begin
      check("up_mole", bus.mole, 1 << (box - 1));
      check("up_box", bus.box_id, box);
      up_n++;
      if (mode == 1 && j == k) begin
        bus.hit = 4'(1 << (box - 1));
        hitd = 1;
      end else if (mode == 2) begin
        bus.hit = 4'(1 << ((box + $urandom_range(0, 2)) % 4));
      end else begin
        bus.hit = 4'b0000;
      end
      if (j == 0) bus.start = 1'b1;
      tick;
      bus.hit = 4'b0000;
      bus.start = 1'b0;
    end
    check("up_len", up_n, hitd ? k + 1 : UPC);
    check("mole_off", bus.mole, 0);
    check("box_off", bus.box_id, 0);
    if (hitd) m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
    else m_miss = (m_miss < SMAX) ? m_miss + 1 : SMAX;
    m_left--;
    check("score", bus.score, m_score);
    check("misses", bus.misses, m_miss);
    check("moles_left", bus.moles_left, m_left);
    check("game_over", bus.game_over, m_left == 0);
  endtask

  task automatic start_round;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    m_score = 0; m_miss = 0; m_left = RLEN;
    check("rs_go", bus.game_over, 0);
    check("rs_left", bus.moles_left, RLEN);
    check("rs_score", bus.score, 0);
    check("rs_miss", bus.misses, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int box, p, cnt, en_seen;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.hit = 4'b0000;
    bus.lfsr_state = 3'b000;
    m_prev = 0;
    repeat (2) tick;
    check("rst_mole", bus.mole, 0);
    check("rst_box", bus.box_id, 0);
    check("rst_score", bus.score, 0);
    check("rst_miss", bus.misses, 0);
    check("rst_left", bus.moles_left, 0);
    check("rst_go", bus.game_over, 0);
    check("rst_en", bus.lfsr_enable, 0);
    reset = 1'b0;
    en_seen = 0;
    repeat (6) begin
      tick;
      if (bus.lfsr_enable) en_seen++;
    end
    check("idle_no_en", en_seen, 0);

    // reset during UP clears everything immediately
    start_round;
    wait_pick(cnt);
    check("gap_len0", cnt, GAPC);
    force_q.push_back(3);
    do_pick(box, p);
    check("box2", box, 2);
    check("mole2", bus.mole, 4'b0010);
    reset = 1'b1;
    #1;
    check("ar_mole", bus.mole, 0);
    check("ar_box", bus.box_id, 0);
    check("ar_left", bus.moles_left, 0);
    check("ar_en", bus.lfsr_enable, 0);
    tick;
    reset = 1'b0;
    m_prev = 0;
    en_seen = 0;
    repeat (6) begin
      tick;
      if (bus.lfsr_enable) en_seen++;
    end
    check("ar_no_en", en_seen, 0);

    // directed round: hit, repick chain, collision, miss, hit
    start_round;
    force_q.push_back(1);
    run_mole(1, 0, box, p);
    check("m1_box", box, 1);
    force_q.push_back(0);
    force_q.push_back(1);
    force_q.push_back(6);
    run_mole(2, 0, box, p);
    check("repick_pulses", p, 3);
    check("repick_box", box, 3);
    run_mole(1, UPC - 1, box, p);
    run_mole(0, 0, box, p);
    run_mole(1, 1, box, p);
    check("r1_score", bus.score, 3);
    check("r1_miss", bus.misses, 2);

    // DONE holds and ignores hits
    bus.hit = 4'b1111;
    tick;
    bus.hit = 4'b0000;
    repeat (3) tick;
    check("done_go", bus.game_over, 1);
    check("done_score", bus.score, 3);
    check("done_en", bus.lfsr_enable, 0);

    // all-hit round: score saturates
    start_round;
    for (int i = 0; i < RLEN; i++)
      run_mole(1, $urandom_range(0, UPC - 1), box, p);
    check("sat_score", bus.score, SMAX);
    check("sat_miss", bus.misses, 0);

    // random rounds
    for (int r = 0; r < 6; r++) begin
      start_round;
      for (int i = 0; i < RLEN; i++)
        run_mole($urandom_range(0, 2),
                 $urandom_range(0, UPC - 1), box, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
